// File: rtl/lsu_rv32i_pkg.sv
// lsu_rv32i_pkg
// Shared definitions for the RV32I load/store unit and the decoder that
// feeds it: load/store type encodings, the LSU FSM state encoding and a
// helper that classifies an access as misaligned for its width.
package lsu_rv32i_pkg;

   // cu_loadtype encodings; 101..111 behave as LW
   localparam logic [2:0] LT_LB  = 3'b000;
   localparam logic [2:0] LT_LH  = 3'b001;
   localparam logic [2:0] LT_LW  = 3'b010;
   localparam logic [2:0] LT_LBU = 3'b011;
   localparam logic [2:0] LT_LHU = 3'b100;

   // cu_storetype encodings; 11 behaves as SW
   localparam logic [1:0] ST_SB = 2'b00;
   localparam logic [1:0] ST_SH = 2'b01;
   localparam logic [1:0] ST_SW = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } lsu_state_t;

   // Half accesses must be 2-byte aligned, word accesses 4-byte aligned.
   // Undefined encodings count as word accesses.
   function automatic logic lsu_misaligned(input logic       is_store,
                                           input logic [2:0] lt,
                                           input logic [1:0] st,
                                           input logic [1:0] off);
      logic is_half;
      logic is_word;
      if (is_store) begin
         is_half = (st == ST_SH);
         is_word = (st != ST_SB) && !is_half;
      end else begin
         is_half = (lt == LT_LH) || (lt == LT_LHU);
         is_word = !is_half && (lt != LT_LB) && (lt != LT_LBU);
      end
      return (is_half && off[0]) || (is_word && (off != 2'b00));
   endfunction

endpackage

// File: rtl/lsu_align_rv32i.sv
// lsu_align_rv32i
// Purely combinational lane logic for the load/store unit.
//   is_store   : 1 = store op, 0 = load op
//   loadtype   : LT_* encoding (used for load extraction)
//   storetype  : ST_* encoding (used for byte enables / write data)
//   off        : byte offset, address bits [1:0]
//   wdata      : rs2 data
//   rdata      : raw memory read word
//   be         : byte enables (all ones for loads)
//   wdata_rep  : write data replicated across the lanes the op may hit
//   rdata_ext  : selected lane, sign/zero extended to 32 bits
module lsu_align_rv32i
   import lsu_rv32i_pkg::*;
(
   input  logic        is_store,
   input  logic [2:0]  loadtype,
   input  logic [1:0]  storetype,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext
);

   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   always_comb begin
      // Halves ignore off[0]: the lane is picked by off[1] alone.
      rd_byte = rdata[{off, 3'b000} +: 8];
      rd_half = rdata[{off[1], 4'b0000} +: 16];

      case (loadtype)
         LT_LB:   rdata_ext = {{24{rd_byte[7]}}, rd_byte};
         LT_LBU:  rdata_ext = {24'h000000, rd_byte};
         LT_LH:   rdata_ext = {{16{rd_half[15]}}, rd_half};
         LT_LHU:  rdata_ext = {16'h0000, rd_half};
         default: rdata_ext = rdata;
      endcase

      case (storetype)
         ST_SB: begin
            be        = 4'b0001 << off;
            wdata_rep = {4{wdata[7:0]}};
         end
         ST_SH: begin
            be        = 4'b0011 << {off[1], 1'b0};
            wdata_rep = {2{wdata[15:0]}};
         end
         default: begin
            be        = 4'b1111;
            wdata_rep = wdata;
         end
      endcase

      if (!is_store) begin
         be = 4'b1111;
      end
   end

endmodule

// File: rtl/lsu_rv32i.sv
// lsu_rv32i
// Load/store unit placed after the decoder. Accepts one memory op in IDLE,
// drives a single req/gnt/rvalid transaction and returns the aligned,
// extended load result with a one-cycle lsu_done pulse.
//
// Ports:
//   clock, reset        : rising-edge clock, async active-high reset
//   lsu_valid           : op present (sampled in IDLE only)
//   cu_store            : 1 store / 0 load
//   cu_loadtype[2:0]    : LB/LH/LW/LBU/LHU
//   cu_storetype[1:0]   : SB/SH/SW
//   lsu_addr, lsu_wdata : effective address, rs2 data
//   lsu_busy            : pipeline stall (combinational)
//   lsu_done            : completion pulse
//   lsu_rdata, lsu_err  : result and error flag, valid with lsu_done
//   mem_req/we/addr/be/wdata, mem_gnt, mem_rvalid, mem_rdata : memory port
//   dbg_state           : current FSM state
//
// Memory handshake: mem_req and every mem_* output are held stable from
// the cycle after acceptance until the cycle mem_gnt is seen high; the
// request is taken on that edge and mem_req drops the next cycle. For a
// load, mem_rvalid is then accepted only in WAIT, at least one cycle
// after the grant.
//
// Parameters: TIMEOUT_CYCLES (0 disables the watchdog), CNT_W.
// Build option: LSU_MISALIGN_TRAP_EN makes misaligned half/word ops
// complete immediately with lsu_err instead of ignoring low address bits.
module lsu_rv32i
   import lsu_rv32i_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        lsu_valid,
   input  logic        cu_store,
   input  logic [2:0]  cu_loadtype,
   input  logic [1:0]  cu_storetype,
   input  logic [31:0] lsu_addr,
   input  logic [31:0] lsu_wdata,
   output logic        lsu_busy,
   output logic        lsu_done,
   output logic [31:0] lsu_rdata,
   output logic        lsu_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic [1:0]  dbg_state
);

   // Counter value seen in the last permitted REQ/WAIT cycle.
   localparam logic [CNT_W-1:0] TO_LAST =
      CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   lsu_state_t       state, state_d;
   logic [CNT_W-1:0] cnt;
   logic             store_q;
   logic [2:0]       lt_q;
   logic [1:0]       off_q;

   logic             accept;
   logic             err_d;
   logic             capture;
   logic             timeout;

   logic [2:0]       al_loadtype;
   logic [1:0]       al_off;
   logic [3:0]       al_be;
   logic [31:0]      al_wdata;
   logic [31:0]      al_rdata;

   // In IDLE the aligner sees the incoming op; afterwards it sees the
   // latched op so load extraction uses the accepted type and offset.
   assign al_loadtype = (state == S_IDLE) ? cu_loadtype  : lt_q;
   assign al_off      = (state == S_IDLE) ? lsu_addr[1:0] : off_q;

   lsu_align_rv32i u_align (
      .is_store  (cu_store),
      .loadtype  (al_loadtype),
      .storetype (cu_storetype),
      .off       (al_off),
      .wdata     (lsu_wdata),
      .rdata     (mem_rdata),
      .be        (al_be),
      .wdata_rep (al_wdata),
      .rdata_ext (al_rdata)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d = state;
      accept  = 1'b0;
      err_d   = 1'b0;
      capture = 1'b0;
      timeout = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);

      case (state)
         S_IDLE: begin
            if (lsu_valid) begin
               accept = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
               if (lsu_misaligned(cu_store, cu_loadtype, cu_storetype,
                                  lsu_addr[1:0])) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
               end else begin
                  state_d = S_REQ;
               end
`else
               state_d = S_REQ;
`endif
            end
         end
         S_REQ: begin
            // A handshake in the timeout cycle still completes normally.
            if (mem_gnt) begin
               state_d = store_q ? S_DONE : S_WAIT;
            end else if (timeout) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               state_d = S_DONE;
               capture = 1'b1;
            end else if (timeout) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= '0;
         mem_wdata <= '0;
         store_q   <= 1'b0;
         lt_q      <= '0;
         off_q     <= '0;
         cnt       <= '0;
         lsu_err   <= 1'b0;
         lsu_rdata <= '0;
      end else begin
         mem_req <= (state_d == S_REQ);
         if (accept) begin
            mem_we    <= cu_store;
            mem_addr  <= {lsu_addr[31:2], 2'b00};
            mem_be    <= al_be;
            mem_wdata <= al_wdata;
            store_q   <= cu_store;
            lt_q      <= cu_loadtype;
            off_q     <= lsu_addr[1:0];
         end
         if ((state == S_REQ) || (state == S_WAIT)) begin
            cnt <= cnt + 1'b1;
         end else begin
            cnt <= '0;
         end
         // Both are nonzero only during the DONE cycle.
         lsu_err   <= err_d;
         lsu_rdata <= capture ? al_rdata : '0;
      end
   end

   assign lsu_done  = (state == S_DONE);
   assign lsu_busy  = (state == S_REQ) || (state == S_WAIT) ||
                      ((state == S_IDLE) && lsu_valid);
   assign dbg_state = state;

endmodule
